// File: rtl/calendar_set_ctrl.sv
// rtl/calendar_set_ctrl.sv - button-driven time/date editor feeding the calendar counter load port
//
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat while inc/dec is held)
//
// Ports:
//   clk, rst_n                  clock; asynchronous active-low reset
//   btn_mode                    raw button: enter edit (IDLE) / abort edit (EDIT_*)
//   btn_next                    raw button: advance to next field
//   btn_inc, btn_dec            raw buttons: step current field up / down
//   cur_sec..cur_year           live time/date from the calendar counter
//   load_ready                  counter accepts a parallel load
//   set_sec..set_year           edited time/date
//   load_valid                  set_* offered for loading (COMMIT)
//   editing                     high in any EDIT_* state
//   field_sel                   0=year 1=month 2=day 3=hour 4=min 5=sec 7=none
module calendar_set_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_PERIOD   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_mode,
   input  logic        btn_next,
   input  logic        btn_inc,
   input  logic        btn_dec,
   input  logic [5:0]  cur_sec,
   input  logic [5:0]  cur_min,
   input  logic [4:0]  cur_hour,
   input  logic [4:0]  cur_day,
   input  logic [3:0]  cur_month,
   input  logic [13:0] cur_year,
   input  logic        load_ready,
   output logic [5:0]  set_sec,
   output logic [5:0]  set_min,
   output logic [4:0]  set_hour,
   output logic [4:0]  set_day,
   output logic [3:0]  set_month,
   output logic [13:0] set_year,
   output logic        load_valid,
   output logic        editing,
   output logic [2:0]  field_sel
);

   // Debounce counter saturates one above the press threshold so the
   // "reached threshold" compare is true for exactly one cycle per press.
   localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 2);
   localparam logic [CW-1:0] DB_HIT = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DB_SAT = CW'(DEBOUNCE_CYCLES + 1);

   // EDIT_* encodings are consecutive and EDIT_SEC+1 is COMMIT, so "next"
   // is a simple increment of the state code.
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      EDIT_YEAR  = 3'd1,
      EDIT_MONTH = 3'd2,
      EDIT_DAY   = 3'd3,
      EDIT_HOUR  = 3'd4,
      EDIT_MIN   = 3'd5,
      EDIT_SEC   = 3'd6,
      COMMIT     = 3'd7
   } state_t;

   state_t state, state_n;

   logic [3:0]         btn_raw, sync1, sync2, press;   // {dec, inc, next, mode}
   logic [3:0][CW-1:0] db_cnt;
   logic [1:0]         rpt_step;                       // {dec, inc}
   logic               mode_p, next_p, inc_step, dec_step, step_up, step_en;

   assign btn_raw = {btn_dec, btn_inc, btn_next, btn_mode};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         db_cnt <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            if (!sync2[i])
               db_cnt[i] <= '0;
            else if (db_cnt[i] != DB_SAT)
               db_cnt[i] <= db_cnt[i] + CW'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++)
         press[i] = (db_cnt[i] == DB_HIT);
   end

`ifdef AUTO_REPEAT_EN
   localparam int            RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int            RW      = $clog2(RMAX + 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

   logic [1:0][RW-1:0] rpt_cnt;
   logic [1:0]         rpt_run, rpt_held;

   // rpt_run=0 counts the initial delay after the press pulse, rpt_run=1
   // counts the repeat period; each terminal count emits one extra step.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rpt_held[i] = (db_cnt[i+2] == DB_SAT) && editing;
         rpt_step[i] = rpt_held[i] && (rpt_cnt[i] == (rpt_run[i] ? RP_LAST : RD_LAST));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_cnt <= '0;
         rpt_run <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!rpt_held[i]) begin
               rpt_cnt[i] <= '0;
               rpt_run[i] <= 1'b0;
            end else if (rpt_step[i]) begin
               rpt_cnt[i] <= '0;
               rpt_run[i] <= 1'b1;
            end else begin
               rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
            end
         end
      end
   end
`else
   logic rpt_params_unused;
   assign rpt_params_unused = (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0);
   assign rpt_step          = 2'b00;
`endif

   assign mode_p   = press[0];
   assign next_p   = press[1];
   assign inc_step = press[2] | rpt_step[0];
   assign dec_step = press[3] | rpt_step[1];
   assign step_up  = inc_step & ~dec_step;
   assign step_en  = inc_step ^ dec_step;      // simultaneous inc+dec cancel

   function automatic logic [4:0] max_day(input logic [3:0] m, input logic [13:0] y);
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: max_day = 5'd30;
         4'd2:                    max_day = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
         default:                 max_day = 5'd31;
      endcase
   endfunction

   // Current field widened to 14 bits with its legal range, stepped with wrap.
   logic [13:0] fld_val, fld_lo, fld_hi, fld_stepped;

   always_comb begin
      fld_val = 14'd0;
      fld_lo  = 14'd0;
      fld_hi  = 14'd0;
      case (state)
         EDIT_YEAR:  begin fld_val = set_year;             fld_hi = 14'd9999; end
         EDIT_MONTH: begin fld_val = {10'd0, set_month};   fld_lo = 14'd1; fld_hi = 14'd12; end
         EDIT_DAY:   begin fld_val = {9'd0, set_day};      fld_lo = 14'd1;
                           fld_hi = {9'd0, max_day(set_month, set_year)}; end
         EDIT_HOUR:  begin fld_val = {9'd0, set_hour};     fld_hi = 14'd23; end
         EDIT_MIN:   begin fld_val = {8'd0, set_min};      fld_hi = 14'd59; end
         EDIT_SEC:   begin fld_val = {8'd0, set_sec};      fld_hi = 14'd59; end
         default:    ;
      endcase
      if (step_up)
         fld_stepped = (fld_val >= fld_hi) ? fld_lo : fld_val + 14'd1;
      else
         fld_stepped = (fld_val <= fld_lo) ? fld_hi : fld_val - 14'd1;
   end

   logic [5:0]  sec_n, min_n;
   logic [4:0]  hour_n, day_n, md;
   logic [3:0]  month_n;
   logic [13:0] year_n;

   always_comb begin
      state_n    = state;
      sec_n      = set_sec;
      min_n      = set_min;
      hour_n     = set_hour;
      day_n      = set_day;
      month_n    = set_month;
      year_n     = set_year;
      md         = 5'd31;
      load_valid = 1'b0;
      editing    = 1'b0;
      field_sel  = 3'd7;
      case (state)
         IDLE: begin
            if (mode_p) begin
               sec_n   = cur_sec;
               min_n   = cur_min;
               hour_n  = cur_hour;
               day_n   = cur_day;
               month_n = cur_month;
               year_n  = cur_year;
               state_n = EDIT_YEAR;
            end
         end
         COMMIT: begin
            load_valid = 1'b1;
            if (load_ready)
               state_n = IDLE;
         end
         default: begin
            editing   = 1'b1;
            field_sel = 3'(state - EDIT_YEAR);
            if (mode_p) begin
               state_n = IDLE;
            end else begin
               if (step_en) begin
                  case (state)
                     EDIT_YEAR: begin
                        year_n = fld_stepped;
                        md     = max_day(set_month, fld_stepped);
                        if (set_day > md) day_n = md;
                     end
                     EDIT_MONTH: begin
                        month_n = fld_stepped[3:0];
                        md      = max_day(fld_stepped[3:0], set_year);
                        if (set_day > md) day_n = md;
                     end
                     EDIT_DAY:  day_n  = fld_stepped[4:0];
                     EDIT_HOUR: hour_n = fld_stepped[4:0];
                     EDIT_MIN:  min_n  = fld_stepped[5:0];
                     default:   sec_n  = fld_stepped[5:0];
                  endcase
               end
               if (next_p)
                  state_n = state_t'(state + 3'd1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         set_sec   <= 6'd0;
         set_min   <= 6'd0;
         set_hour  <= 5'd0;
         set_day   <= 5'd1;
         set_month <= 4'd1;
         set_year  <= 14'd2024;
      end else begin
         state     <= state_n;
         set_sec   <= sec_n;
         set_min   <= min_n;
         set_hour  <= hour_n;
         set_day   <= day_n;
         set_month <= month_n;
         set_year  <= year_n;
      end
   end

endmodule
